// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode encoding,
// datapath widths and common constants.
// Imported by alu_rs and alu_rs_sel.
package alu_rs_pkg;

    localparam int Data_Len     = 32;
    localparam int Addr_Len     = 32;
    localparam int Rob_Addr_Len = 4;
    localparam int Shamt_Len    = 5;
    localparam int Op_Len       = 6;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [Data_Len-1:0] Zero_Data = '0;

    // Micro-op encoding shared with decode and the ALU stage
    typedef enum logic [Op_Len-1:0] {
        op_nop   = 6'd0,
        op_lui   = 6'd1,
        op_auipc = 6'd2,
        op_jal   = 6'd3,
        op_jalr  = 6'd4,
        op_beq   = 6'd5,
        op_bne   = 6'd6,
        op_blt   = 6'd7,
        op_bge   = 6'd8,
        op_addi  = 6'd20,
        op_slli  = 6'd26,
        op_add   = 6'd29,
        op_sub   = 6'd30,
        op_xor   = 6'd33,
        op_or    = 6'd37,
        op_and   = 6'd38
    } op_e;

endpackage

// File: rtl/alu_rs_sel.sv
// Lowest-index priority encoder over a request vector.
// Purely combinational; found=0 and idx=0 when no bit is set.
// Used for both free-entry and ready-entry selection.
module alu_rs_sel
    import alu_rs_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit wins
    always_comb begin
        found = False;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = True;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds micro-ops until both operands
// are valid, then issues the lowest ready entry as a registered packet (>=2 cycles).
// No ALU back-pressure; rs_full tells dispatch to stall. Optional RS_DISPATCH_BYPASS_EN.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH = 16,
    parameter int ROB_W    = Rob_Addr_Len
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 has_misbranch,
    input  logic                 has_to_rs,
    input  logic [Op_Len-1:0]    in_op,
    input  logic [Data_Len-1:0]  in_imm,
    input  logic [Addr_Len-1:0]  in_pc,
    input  logic [Shamt_Len-1:0] in_shamt,
    input  logic [ROB_W-1:0]     in_rd_robnum,
    input  logic                 in_rs1_ready,
    input  logic                 in_rs2_ready,
    input  logic [Data_Len-1:0]  in_rs1_data,
    input  logic [Data_Len-1:0]  in_rs2_data,
    input  logic [ROB_W-1:0]     in_rs1_robnum,
    input  logic [ROB_W-1:0]     in_rs2_robnum,
    input  logic                 alu_cdb_valid,
    input  logic [ROB_W-1:0]     alu_cdb_robnum,
    input  logic [Data_Len-1:0]  alu_cdb_data,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_W-1:0]     lsb_cdb_robnum,
    input  logic [Data_Len-1:0]  lsb_cdb_data,
    output logic                 rs_full,
    output logic                 has_to_alu,
    output logic [Op_Len-1:0]    op,
    output logic [Data_Len-1:0]  imm,
    output logic [Addr_Len-1:0]  pc,
    output logic [Shamt_Len-1:0] shamt,
    output logic [ROB_W-1:0]     out_rd_robnum,
    output logic [Data_Len-1:0]  rs1_oprand,
    output logic [Data_Len-1:0]  rs2_oprand
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    // Entry storage
    logic [RS_DEPTH-1:0]  busy, q1_rdy, q2_rdy;
    logic [Op_Len-1:0]    e_op    [RS_DEPTH];
    logic [Data_Len-1:0]  e_imm   [RS_DEPTH];
    logic [Addr_Len-1:0]  e_pc    [RS_DEPTH];
    logic [Shamt_Len-1:0] e_shamt [RS_DEPTH];
    logic [ROB_W-1:0]     e_rd    [RS_DEPTH];
    logic [ROB_W-1:0]     e_tag1  [RS_DEPTH];
    logic [ROB_W-1:0]     e_tag2  [RS_DEPTH];
    logic [Data_Len-1:0]  e_val1  [RS_DEPTH];
    logic [Data_Len-1:0]  e_val2  [RS_DEPTH];

    logic              free_found, iss_found;
    logic [IDX_W-1:0]  free_idx, iss_idx;
    logic [RS_DEPTH-1:0] eligible;

    // Dispatch-port operand after optional same-cycle CDB capture
    logic                d1_rdy, d2_rdy;
    logic [Data_Len-1:0] d1_val, d2_val;

    assign rs_full  = &busy;
    // Eligibility uses flags as registered, so a wakeup issues one edge later
    assign eligible = busy & q1_rdy & q2_rdy;

    alu_rs_sel #(.N(RS_DEPTH), .IW(IDX_W)) u_sel_free (
        .req   (~busy),
        .found (free_found),
        .idx   (free_idx)
    );

    alu_rs_sel #(.N(RS_DEPTH), .IW(IDX_W)) u_sel_iss (
        .req   (eligible),
        .found (iss_found),
        .idx   (iss_idx)
    );

    // Resolve dispatch operands, optionally catching a broadcast in flight
    always_comb begin
        d1_rdy = in_rs1_ready;
        d1_val = in_rs1_data;
        d2_rdy = in_rs2_ready;
        d2_val = in_rs2_data;
`ifdef RS_DISPATCH_BYPASS_EN
        if (!in_rs1_ready) begin
            if (alu_cdb_valid && alu_cdb_robnum == in_rs1_robnum) begin
                d1_rdy = True;
                d1_val = alu_cdb_data;
            end else if (lsb_cdb_valid && lsb_cdb_robnum == in_rs1_robnum) begin
                d1_rdy = True;
                d1_val = lsb_cdb_data;
            end
        end
        if (!in_rs2_ready) begin
            if (alu_cdb_valid && alu_cdb_robnum == in_rs2_robnum) begin
                d2_rdy = True;
                d2_val = alu_cdb_data;
            end else if (lsb_cdb_valid && lsb_cdb_robnum == in_rs2_robnum) begin
                d2_rdy = True;
                d2_val = lsb_cdb_data;
            end
        end
`endif
    end

    // Entry state, wakeup, dispatch and issue register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= '0;
            q1_rdy        <= '0;
            q2_rdy        <= '0;
            has_to_alu    <= False;
            op            <= '0;
            imm           <= Zero_Data;
            pc            <= '0;
            shamt         <= '0;
            out_rd_robnum <= '0;
            rs1_oprand    <= Zero_Data;
            rs2_oprand    <= Zero_Data;
            for (int i = 0; i < RS_DEPTH; i++) begin
                e_op[i]    <= '0;
                e_imm[i]   <= Zero_Data;
                e_pc[i]    <= '0;
                e_shamt[i] <= '0;
                e_rd[i]    <= '0;
                e_tag1[i]  <= '0;
                e_tag2[i]  <= '0;
                e_val1[i]  <= Zero_Data;
                e_val2[i]  <= Zero_Data;
            end
        end else if (has_misbranch) begin
            busy       <= '0;
            has_to_alu <= False;
        end else if (rdy) begin
            // Wakeup: only busy entries listen, so the free slot targeted by
            // dispatch below is never written twice in one cycle
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i] && !q1_rdy[i]) begin
                    if (alu_cdb_valid && alu_cdb_robnum == e_tag1[i]) begin
                        q1_rdy[i] <= True;
                        e_val1[i] <= alu_cdb_data;
                    end else if (lsb_cdb_valid && lsb_cdb_robnum == e_tag1[i]) begin
                        q1_rdy[i] <= True;
                        e_val1[i] <= lsb_cdb_data;
                    end
                end
                if (busy[i] && !q2_rdy[i]) begin
                    if (alu_cdb_valid && alu_cdb_robnum == e_tag2[i]) begin
                        q2_rdy[i] <= True;
                        e_val2[i] <= alu_cdb_data;
                    end else if (lsb_cdb_valid && lsb_cdb_robnum == e_tag2[i]) begin
                        q2_rdy[i] <= True;
                        e_val2[i] <= lsb_cdb_data;
                    end
                end
            end

            // Issue: the freed slot stays unavailable to dispatch until next cycle
            has_to_alu <= iss_found;
            if (iss_found) begin
                busy[iss_idx] <= False;
                op            <= e_op[iss_idx];
                imm           <= e_imm[iss_idx];
                pc            <= e_pc[iss_idx];
                shamt         <= e_shamt[iss_idx];
                out_rd_robnum <= e_rd[iss_idx];
                rs1_oprand    <= e_val1[iss_idx];
                rs2_oprand    <= e_val2[iss_idx];
            end

            // Dispatch into the lowest free entry; dropped when full
            if (has_to_rs && free_found) begin
                busy[free_idx]    <= True;
                e_op[free_idx]    <= in_op;
                e_imm[free_idx]   <= in_imm;
                e_pc[free_idx]    <= in_pc;
                e_shamt[free_idx] <= in_shamt;
                e_rd[free_idx]    <= in_rd_robnum;
                e_tag1[free_idx]  <= in_rs1_robnum;
                e_tag2[free_idx]  <= in_rs2_robnum;
                q1_rdy[free_idx]  <= d1_rdy;
                q2_rdy[free_idx]  <= d2_rdy;
                e_val1[free_idx]  <= d1_val;
                e_val2[free_idx]  <= d2_val;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs with hand-computed expectations.
// Covers reset, issue latency, wakeup, full/drop, issue order, flush, bypass.
// Build with or without RS_DISPATCH_BYPASS_EN.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        has_misbranch = 1'b0;
    logic        has_to_rs = 1'b0;
    logic [5:0]  in_op = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_shamt = '0;
    logic [3:0]  in_rd_robnum = '0;
    logic        in_rs1_ready = 1'b0, in_rs2_ready = 1'b0;
    logic [31:0] in_rs1_data = '0, in_rs2_data = '0;
    logic [3:0]  in_rs1_robnum = '0, in_rs2_robnum = '0;
    logic        alu_cdb_valid = 1'b0;
    logic [3:0]  alu_cdb_robnum = '0;
    logic [31:0] alu_cdb_data = '0;
    logic        lsb_cdb_valid = 1'b0;
    logic [3:0]  lsb_cdb_robnum = '0;
    logic [31:0] lsb_cdb_data = '0;
    logic        rs_full, has_to_alu;
    logic [5:0]  op;
    logic [31:0] imm, pc, rs1_oprand, rs2_oprand;
    logic [4:0]  shamt;
    logic [3:0]  out_rd_robnum;

    int checks = 0;
    int failures = 0;

    alu_rs #(.RS_DEPTH(16), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
        .has_to_rs(has_to_rs), .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc),
        .in_shamt(in_shamt), .in_rd_robnum(in_rd_robnum),
        .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_robnum(in_rs1_robnum), .in_rs2_robnum(in_rs2_robnum),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_robnum(alu_cdb_robnum),
        .alu_cdb_data(alu_cdb_data), .lsb_cdb_valid(lsb_cdb_valid),
        .lsb_cdb_robnum(lsb_cdb_robnum), .lsb_cdb_data(lsb_cdb_data),
        .rs_full(rs_full), .has_to_alu(has_to_alu), .op(op), .imm(imm), .pc(pc),
        .shamt(shamt), .out_rd_robnum(out_rd_robnum),
        .rs1_oprand(rs1_oprand), .rs2_oprand(rs2_oprand)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one dispatch for a single edge
    task automatic disp(input logic [5:0] o, input logic r1, input logic [31:0] v1,
                        input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                        input logic [3:0] t2, input logic [3:0] rd, input logic [31:0] im);
        has_to_rs = 1'b1;
        in_op = o; in_imm = im; in_pc = 32'h1000 + 32'(rd) * 4; in_shamt = 5'd0;
        in_rd_robnum = rd;
        in_rs1_ready = r1; in_rs1_data = v1; in_rs1_robnum = t1;
        in_rs2_ready = r2; in_rs2_data = v2; in_rs2_robnum = t2;
        step();
        has_to_rs = 1'b0;
    endtask

    task automatic flush();
        has_misbranch = 1'b1;
        step();
        has_misbranch = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_vld", 32'(has_to_alu), 32'd0);
        check("rst_op", 32'(op), 32'd0);
        check("rst_rs1", rs1_oprand, 32'd0);
        check("rst_full", 32'(rs_full), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // addi: ready at dispatch, issues after two edges, pulse is one cycle
        disp(op_addi, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 4'd2, 32'd3);
        check("addi_early", 32'(has_to_alu), 32'd0);
        step();
        check("addi_vld", 32'(has_to_alu), 32'd1);
        check("addi_op", 32'(op), 32'(op_addi));
        check("addi_rs1", rs1_oprand, 32'd5);
        check("addi_imm", imm, 32'd3);
        check("addi_rd", 32'(out_rd_robnum), 32'd2);
        check("addi_pc", pc, 32'h1008);
        step();
        check("addi_pulse", 32'(has_to_alu), 32'd0);
        check("addi_hold", rs1_oprand, 32'd5);

        // add waiting on tag 7 from the ALU bus
        disp(op_add, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 4'd3, 32'd0);
        step(); step();
        check("add_wait", 32'(has_to_alu), 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd7; alu_cdb_data = 32'h10;
        step();
        alu_cdb_valid = 1'b0;
        check("add_wake", 32'(has_to_alu), 32'd0);
        step();
        check("add_vld", 32'(has_to_alu), 32'd1);
        check("add_rs1", rs1_oprand, 32'h10);
        check("add_rs2", rs2_oprand, 32'd1);
        check("add_rd", 32'(out_rd_robnum), 32'd3);
        step();

        // Fill all 16 entries; entry i waits on tag i
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("not_full", 32'(rs_full), 32'd0);
            disp(op_sub, 1'b0, 32'd0, 4'(i), 1'b1, 32'd2, 4'd0, 4'(i), 32'(i));
        end
        check("full", 32'(rs_full), 32'd1);
        disp(op_or, 1'b1, 32'h99, 4'd0, 1'b1, 32'h99, 4'd0, 4'd14, 32'd0);
        step();
        check("drop", 32'(has_to_alu), 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd9; alu_cdb_data = 32'h900;
        step();
        alu_cdb_valid = 1'b0;
        check("full_wake", 32'(rs_full), 32'd1);
        step();
        check("e9_vld", 32'(has_to_alu), 32'd1);
        check("e9_rd", 32'(out_rd_robnum), 32'd9);
        check("e9_rs1", rs1_oprand, 32'h900);
        check("e9_imm", imm, 32'd9);
        check("full_fall", 32'(rs_full), 32'd0);
        step();
        check("drop_none", 32'(has_to_alu), 32'd0);
        flush();

        // Entries 3,4,5 become ready together; 4 wakes rs1 from ALU and rs2 from LSB
        for (int i = 0; i < 6; i++) begin
            if (i == 4)
                disp(op_and, 1'b0, 32'd0, 4'd3, 1'b0, 32'd0, 4'd6, 4'd4, 32'd0);
            else
                disp(op_xor, 1'b0, 32'd0, (i == 3 || i == 5) ? 4'd3 : 4'd1,
                     1'b1, 32'd0, 4'd0, 4'(i), 32'd0);
        end
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd3; alu_cdb_data = 32'h33;
        lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd6; lsb_cdb_data = 32'h66;
        step();
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
        step();
        check("ord_a_rd", 32'(out_rd_robnum), 32'd3);
        check("ord_a_rs1", rs1_oprand, 32'h33);
        step();
        check("ord_b_vld", 32'(has_to_alu), 32'd1);
        check("ord_b_rd", 32'(out_rd_robnum), 32'd4);
        check("ord_b_rs2", rs2_oprand, 32'h66);
        step();
        check("ord_c_rd", 32'(out_rd_robnum), 32'd5);
        step();
        check("ord_end", 32'(has_to_alu), 32'd0);
        flush();

        // Flush with rdy low frees four pending entries
        for (int i = 0; i < 4; i++)
            disp(op_add, 1'b0, 32'd0, 4'd10, 1'b1, 32'd0, 4'd0, 4'(i), 32'd0);
        rdy = 1'b0;
        flush();
        rdy = 1'b1;
        check("fl_vld", 32'(has_to_alu), 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_robnum = 4'd10; alu_cdb_data = 32'hBAD;
        step();
        alu_cdb_valid = 1'b0;
        step();
        check("fl_noiss", 32'(has_to_alu), 32'd0);
        step();
        check("fl_noiss2", 32'(has_to_alu), 32'd0);

        // rdy low holds a ready dispatch off
        rdy = 1'b0;
        disp(op_add, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd1, 32'd0);
        step();
        check("rdy_hold", 32'(has_to_alu), 32'd0);
        rdy = 1'b1;
        step();

        // rs2 tag 4 broadcast on LSB bus in the dispatch cycle
        lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd4; lsb_cdb_data = 32'hAB;
        disp(op_add, 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 4'd4, 4'd8, 32'd0);
        lsb_cdb_valid = 1'b0;
        step();
`ifdef RS_DISPATCH_BYPASS_EN
        check("byp_vld", 32'(has_to_alu), 32'd1);
        check("byp_rs2", rs2_oprand, 32'hAB);
`else
        check("byp_pend", 32'(has_to_alu), 32'd0);
        lsb_cdb_valid = 1'b1; lsb_cdb_robnum = 4'd4; lsb_cdb_data = 32'hCD;
        step();
        lsb_cdb_valid = 1'b0;
        step();
        check("late_vld", 32'(has_to_alu), 32'd1);
        check("late_rs2", rs2_oprand, 32'hCD);
`endif
        check("byp_rd", 32'(out_rd_robnum), 32'd8);
        step();
        flush();

        // Asynchronous reset mid-operation
        disp(op_addi, 1'b1, 32'h44, 4'd0, 1'b1, 32'd0, 4'd0, 4'd5, 32'd1);
        step();
        check("pre_rst", 32'(has_to_alu), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_vld", 32'(has_to_alu), 32'd0);
        check("arst_rs1", rs1_oprand, 32'd0);
        check("arst_rd", 32'(out_rd_robnum), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
